// File: rtl/tlb_pkg.sv
// Shared definitions for the Sv32 page-table walker: PTE bit positions, walker states,
// fault cause encodings and TLB permission packing.
package tlb_pkg;

   localparam int unsigned PTE_V = 0;
   localparam int unsigned PTE_R = 1;
   localparam int unsigned PTE_W = 2;
   localparam int unsigned PTE_X = 3;
   localparam int unsigned PTE_U = 4;
   localparam int unsigned PTE_A = 6;
   localparam int unsigned PTE_D = 7;

   typedef enum logic [2:0] {
      StIdle,
      StL1Req,
      StL1Wait,
      StL0Req,
      StL0Wait,
      StFill,
      StFault,
      StDrain
   } ptw_state_e;

   localparam logic [1:0] CauseNone   = 2'b00;
   localparam logic [1:0] CauseAccess = 2'b01;
   localparam logic [1:0] CausePage   = 2'b10;

   // TLB permission field is {U,X,W,R}
   function automatic logic [3:0] pack_perm(input logic [31:0] pte);
      return {pte[PTE_U], pte[PTE_X], pte[PTE_W], pte[PTE_R]};
   endfunction

endpackage

// File: rtl/tlb_pte_check.sv
// Combinational Sv32 PTE decode shared by both walk levels.
// PTW_AD_CHECK_EN: when defined, leaves with A=0 (or D=0 on a write) raise a page fault.
module tlb_pte_check
   import tlb_pkg::*;
(
   input  logic [31:0] pte,
   input  logic        level,
   input  logic        rw,
   output logic        is_leaf,
   output logic        fault,
   output logic [1:0]  cause,
   output logic [21:0] next_ppn
);

   logic bad_enc;
   logic misaligned;
   logic dangling;
   logic ad_fault;
   logic unused_bits;

   assign unused_bits = ^{rw, pte[9:4]};

   always_comb begin
      is_leaf    = pte[PTE_R] | pte[PTE_X];
      bad_enc    = ~pte[PTE_V] | (~pte[PTE_R] & pte[PTE_W]);
      // level=1 is the root table; a leaf there is a superpage needing PPN[9:0]==0
      misaligned = level & is_leaf & (pte[19:10] != 10'd0);
      dangling   = ~level & ~is_leaf;
`ifdef PTW_AD_CHECK_EN
      ad_fault   = is_leaf & (~pte[PTE_A] | (rw & ~pte[PTE_D]));
`else
      ad_fault   = 1'b0;
`endif
      fault      = bad_enc | misaligned | dangling | ad_fault;
      cause      = fault ? CausePage : CauseNone;
      next_ppn   = pte[31:10];
   end

endmodule

// File: rtl/tlb_ptw.sv
// Sv32 two-level page-table walker and TLB refill controller for the frontend TLB.
// PTW_AD_CHECK_EN (optional) enables accessed/dirty-bit faulting on leaf PTEs.
module tlb_ptw
   import tlb_pkg::*;
#(
   parameter int unsigned TAG_WIDTH   = 20,
   parameter int unsigned PPN_WIDTH   = 22,
   parameter int unsigned PA_WIDTH    = 34,
   parameter int unsigned TLB_ENTRIES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [PPN_WIDTH-1:0]           satp_ppn,
   input  logic                           miss_valid,
   input  logic [TAG_WIDTH-1:0]           miss_vpn,
   input  logic                           miss_rw,
   output logic                           miss_ready,
   output logic                           mem_req_valid,
   output logic [PA_WIDTH-1:0]            mem_req_addr,
   input  logic                           mem_req_ready,
   input  logic                           mem_resp_valid,
   input  logic [31:0]                    mem_resp_data,
   input  logic                           mem_resp_err,
   output logic                           fill_valid,
   output logic [$clog2(TLB_ENTRIES)-1:0] fill_idx,
   output logic [TAG_WIDTH-1:0]           fill_vpn,
   output logic [PPN_WIDTH-1:0]           fill_ppn,
   output logic [3:0]                     fill_perm,
   output logic                           fault_valid,
   output logic [1:0]                     fault_cause
);

   localparam int unsigned IdxW = $clog2(TLB_ENTRIES);

   ptw_state_e           state_q, state_d;
   logic [TAG_WIDTH-1:0] vpn_q, vpn_d;
   logic                 rw_q, rw_d;
   logic [PA_WIDTH-1:0]  addr_q, addr_d;
   logic [PPN_WIDTH-1:0] ppn_q, ppn_d;
   logic [3:0]           perm_q, perm_d;
   logic [1:0]           cause_q, cause_d;
   logic [IdxW-1:0]      idx_q, idx_d;

   logic                 chk_leaf;
   logic                 chk_fault;
   logic [1:0]           chk_cause;
   logic [21:0]          chk_next_ppn;

   tlb_pte_check u_pte_check (
      .pte      (mem_resp_data),
      .level    (state_q == StL1Wait),
      .rw       (rw_q),
      .is_leaf  (chk_leaf),
      .fault    (chk_fault),
      .cause    (chk_cause),
      .next_ppn (chk_next_ppn)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         vpn_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         ppn_q   <= '0;
         perm_q  <= '0;
         cause_q <= CauseNone;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         ppn_q   <= ppn_d;
         perm_q  <= perm_d;
         cause_q <= cause_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      ppn_d   = ppn_q;
      perm_d  = perm_q;
      cause_d = cause_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (miss_valid) begin
               vpn_d   = miss_vpn;
               rw_d    = miss_rw;
               addr_d  = {satp_ppn, miss_vpn[19:10], 2'b00};
               state_d = StL1Req;
            end
         end
         StL1Req, StL0Req: begin
            if (flush) begin
               state_d = StIdle;
            end else if (mem_req_ready) begin
               state_d = (state_q == StL1Req) ? StL1Wait : StL0Wait;
            end
         end
         StL1Wait, StL0Wait: begin
            // A response coinciding with flush is consumed here, so no drain is needed
            if (mem_resp_valid) begin
               if (flush) begin
                  state_d = StIdle;
               end else if (mem_resp_err) begin
                  cause_d = CauseAccess;
                  state_d = StFault;
               end else if (chk_fault) begin
                  cause_d = chk_cause;
                  state_d = StFault;
               end else if (chk_leaf) begin
                  perm_d  = pack_perm(mem_resp_data);
                  ppn_d   = (state_q == StL1Wait) ? {chk_next_ppn[PPN_WIDTH-1:10], vpn_q[9:0]}
                                                  : chk_next_ppn;
                  state_d = StFill;
               end else begin
                  addr_d  = {chk_next_ppn, vpn_q[9:0], 2'b00};
                  state_d = StL0Req;
               end
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         StFill: begin
            idx_d   = (idx_q == IdxW'(TLB_ENTRIES - 1)) ? '0 : idx_q + 1'b1;
            state_d = StIdle;
         end
         StFault: state_d = StIdle;
         StDrain: begin
            if (mem_resp_valid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      miss_ready    = rst & (state_q == StIdle);
      mem_req_valid = (state_q == StL1Req) | (state_q == StL0Req);
      mem_req_addr  = mem_req_valid ? addr_q : '0;
      fill_valid    = (state_q == StFill);
      fill_idx      = idx_q;
      fill_vpn      = vpn_q;
      fill_ppn      = ppn_q;
      fill_perm     = perm_q;
      fault_valid   = (state_q == StFault);
      fault_cause   = fault_valid ? cause_q : CauseNone;
   end

endmodule

// File: tb/tb_tlb_ptw.sv
// Self-checking bench for tlb_ptw: directed and randomized walks scored against a
// rule-level model of Sv32 walk outcomes, plus flush and reset scenarios.
module tb_tlb_ptw;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [21:0] satp_ppn = '0;
   logic        miss_valid = 1'b0;
   logic [19:0] miss_vpn = '0;
   logic        miss_rw = 1'b0;
   logic        miss_ready;
   logic        mem_req_valid;
   logic [33:0] mem_req_addr;
   logic        mem_req_ready = 1'b1;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        mem_resp_err = 1'b0;
   logic        fill_valid;
   logic [3:0]  fill_idx;
   logic [19:0] fill_vpn;
   logic [21:0] fill_ppn;
   logic [3:0]  fill_perm;
   logic        fault_valid;
   logic [1:0]  fault_cause;

   int          tests = 0;
   int          fails = 0;
   int          exp_idx = 0;

   tlb_ptw dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .satp_ppn       (satp_ppn),
      .miss_valid     (miss_valid),
      .miss_vpn       (miss_vpn),
      .miss_rw        (miss_rw),
      .miss_ready     (miss_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .fill_valid     (fill_valid),
      .fill_idx       (fill_idx),
      .fill_vpn       (fill_vpn),
      .fill_ppn       (fill_ppn),
      .fill_perm      (fill_perm),
      .fault_valid    (fault_valid),
      .fault_cause    (fault_cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Would a walk stop with a page fault on this PTE?
   function automatic bit pte_faults(input logic [31:0] pte, input bit root, input bit rw);
      bit leaf;
      leaf = pte[1] | pte[3];
      if (!pte[0] || (!pte[1] && pte[2])) return 1'b1;
      if (leaf && root && pte[19:10] != 10'd0) return 1'b1;
      if (!leaf && !root) return 1'b1;
`ifdef PTW_AD_CHECK_EN
      if (leaf && (!pte[6] || (rw && !pte[7]))) return 1'b1;
`else
      if (rw && 1'b0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] gen_pte();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return {r[31:10], 10'h001};
         1:       return {r[31:20], 10'h000, r[9:2], 2'b11};
         2:       return {r[31:2], 2'b11};
         default: return r;
      endcase
   endfunction

   // Present one PTE read: request seen, accepted, answered one cycle later
   task automatic serve(input logic [33:0] addr, input logic [31:0] pte, input logic err,
                        input string lvl);
      @(negedge clk);
      check({lvl, "_req_valid"}, mem_req_valid, 1);
      check({lvl, "_req_addr"}, mem_req_addr, addr);
      check({lvl, "_busy"}, miss_ready, 0);
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = pte;
      mem_resp_err   = err;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
   endtask

   task automatic walk(input logic [19:0] vpn, input bit rw, input logic [31:0] p1,
                       input bit e1, input logic [31:0] p0, input bit e0, input bit fl);
      logic [33:0] a1, a0;
      bit          two, exp_fill;
      logic [1:0]  exp_cause;
      logic [21:0] exp_ppn;
      logic [3:0]  exp_perm;
      a1 = {satp_ppn, vpn[19:10], 2'b00};
      a0 = '0;
      two = 1'b0;
      exp_fill = 1'b0;
      exp_cause = 2'b00;
      exp_ppn = '0;
      exp_perm = '0;
      if (e1) exp_cause = 2'b01;
      else if (pte_faults(p1, 1'b1, rw)) exp_cause = 2'b10;
      else if (p1[1] | p1[3]) begin
         exp_fill = 1'b1;
         exp_ppn  = {p1[31:20], vpn[9:0]};
         exp_perm = {p1[4], p1[3], p1[2], p1[1]};
      end else begin
         two = 1'b1;
         a0  = {p1[31:10], vpn[9:0], 2'b00};
         if (e0) exp_cause = 2'b01;
         else if (pte_faults(p0, 1'b0, rw)) exp_cause = 2'b10;
         else begin
            exp_fill = 1'b1;
            exp_ppn  = p0[31:10];
            exp_perm = {p0[4], p0[3], p0[2], p0[1]};
         end
      end
      @(negedge clk);
      check("idle_ready", miss_ready, 1);
      miss_valid = 1'b1;
      miss_vpn   = vpn;
      miss_rw    = rw;
      flush      = fl;
      @(posedge clk);
      #1;
      miss_valid = 1'b0;
      flush      = 1'b0;
      serve(a1, p1, e1, "l1");
      if (two) serve(a0, p0, e0, "l0");
      @(negedge clk);
      check("fill_valid", fill_valid, exp_fill);
      check("fault_valid", fault_valid, !exp_fill);
      check("fault_cause", fault_cause, exp_cause);
      if (exp_fill) begin
         check("fill_vpn", fill_vpn, vpn);
         check("fill_ppn", fill_ppn, exp_ppn);
         check("fill_perm", fill_perm, exp_perm);
         check("fill_idx", fill_idx, exp_idx);
         exp_idx = (exp_idx + 1) % 16;
      end
      @(negedge clk);
      check("pulse_end", {fill_valid, fault_valid, miss_ready}, 3'b001);
   endtask

   initial begin
      logic [31:0] r;
      #1;
      check("rst_ctl", {miss_ready, mem_req_valid, fill_valid, fault_valid, fault_cause}, 0);
      check("rst_data", {mem_req_addr, fill_idx, fill_ppn}, 0);
      #20 rst = 1'b1;

      // Two-level walk, superpage, superpage misaligned
      satp_ppn = 22'h00100;
      walk(20'h12345, 1'b0, 32'h0020_0001, 1'b0, 32'h0ABC_D0CF, 1'b0, 1'b0);
      walk(20'h12345, 1'b0, 32'h0020_0001, 1'b0, 32'h0ABC_D00F, 1'b0, 1'b0);
      walk(20'h12345, 1'b0, 32'h1000_00CF, 1'b0, 32'h0, 1'b0, 1'b0);
      walk(20'h12345, 1'b0, 32'h1000_04CF, 1'b0, 32'h0, 1'b0, 1'b0);

      // Faults: invalid root, bus error, non-leaf at level 0, bus error at level 0
      walk(20'h0ABCD, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
      walk(20'h0ABCD, 1'b0, 32'h0020_0001, 1'b1, 32'h0, 1'b0, 1'b0);
      walk(20'h0ABCD, 1'b0, 32'h0020_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
      walk(20'h0ABCD, 1'b1, 32'h0020_0001, 1'b0, 32'h0ABC_D0CF, 1'b1, 1'b0);

      // Round-robin index across 17 fills
      for (int i = 0; i < 17; i++) begin
         r = $urandom;
         walk(r[19:0], 1'b0, {r[31:20], 10'h000, 10'h0CF}, 1'b0, 32'h0, 1'b0, 1'b0);
      end

      // Randomized walks against the model
      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         satp_ppn = r[21:0];
         r = $urandom;
         walk(r[19:0], r[20], gen_pte(), ($urandom_range(0, 7) == 0), gen_pte(),
              ($urandom_range(0, 7) == 0), 1'b0);
      end

      // Flush coinciding with a miss handshake: miss still accepted
      satp_ppn = 22'h00100;
      walk(20'h12345, 1'b0, 32'h1000_00CF, 1'b0, 32'h0, 1'b0, 1'b1);

      // Flush in L1 wait; response three cycles later is swallowed
      @(negedge clk);
      miss_valid = 1'b1;
      miss_vpn   = 20'h54321;
      @(posedge clk);
      #1 miss_valid = 1'b0;
      @(negedge clk);
      check("drn_req", mem_req_valid, 1);
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("drn_wait", {fill_valid, fault_valid, miss_ready, mem_req_valid}, 0);
      end
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1000_00CF;
      @(negedge clk);
      check("drn_busy", miss_ready, 0);
      @(posedge clk);
      #1 mem_resp_valid = 1'b0;
      @(negedge clk);
      check("drn_done", {fill_valid, fault_valid, miss_ready}, 3'b001);

      // Response and flush together in wait: consumed, straight to idle
      @(negedge clk);
      miss_valid = 1'b1;
      @(posedge clk);
      #1 miss_valid = 1'b0;
      @(posedge clk);
      #1;
      flush          = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1000_00CF;
      @(posedge clk);
      #1;
      flush          = 1'b0;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check("rf_idle", {fill_valid, fault_valid, miss_ready, mem_req_valid}, 4'b0010);

      // Flush in L0 request while memory stalls
      @(negedge clk);
      miss_valid = 1'b1;
      miss_vpn   = 20'h12345;
      @(posedge clk);
      #1 miss_valid = 1'b0;
      serve({satp_ppn, 10'h048, 2'b00}, 32'h0020_0001, 1'b0, "fl1");
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("l0_stall_addr", mem_req_addr, {22'h00800, 10'h345, 2'b00});
      @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("l0_hold", {mem_req_valid, mem_req_addr}, {1'b1, 22'h00800, 10'h345, 2'b00});
      @(posedge clk);
      #1;
      flush         = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      check("l0_flushed", {miss_ready, mem_req_valid, fill_valid, fault_valid}, 4'b1000);

      // Make the fill index non-zero, then reset mid L0 wait
      walk(20'h12345, 1'b0, 32'h1000_00CF, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      miss_valid = 1'b1;
      @(posedge clk);
      #1 miss_valid = 1'b0;
      serve({satp_ppn, 10'h048, 2'b00}, 32'h0020_0001, 1'b0, "rs1");
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_ctl", {miss_ready, mem_req_valid, fill_valid, fault_valid, fault_cause}, 0);
      check("mid_rst_addr", mem_req_addr, 0);
      check("mid_rst_fill", {fill_idx, fill_vpn, fill_ppn, fill_perm}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_idx = 0;

      // Write miss to a leaf with D=0: faults only when A/D checking is built in
      walk(20'h12345, 1'b1, 32'h0020_0001, 1'b0, 32'h0ABC_D047, 1'b0, 1'b0);
      walk(20'h12345, 1'b0, 32'h0020_0001, 1'b0, 32'h0ABC_D047, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
